rr_mux2_feeder: RTL and testbench

//   Two-channel round-robin arbiter and output register that feeds the 2:1 gate-level mux stage.

---
 rtl/rr_mux2_feeder.sv | 164 ++++++++++++++++
 tb/tb_rr_mux2_feeder.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux2_feeder.sv
// rtl/rr_mux2_feeder.sv - two-channel round-robin arbiter with registered output for the 2:1 mux stage
//
// Purpose
//   Arbitrates between two valid/ready word sources. It grants at most one
//   source per cycle and captures the winning word in a single-entry output
//   register. The register presents the word with a sel bit (0 = channel 0,
//   1 = channel 1) that drives the downstream 2:1 mux select. A pop and an
//   accept in the same cycle are allowed, so the stage sustains one word per
//   cycle with one cycle of latency.
//
// Optional feature macro
//   ARB_GRANT_CNT_EN : adds the gnt_cnt0/gnt_cnt1 per-channel accept counters.
//                      They wrap at 2^CNT_W.
//
// Parameters
//   WIDTH  data width of each channel and of out_data
//   CNT_W  grant-counter width (only meaningful with ARB_GRANT_CNT_EN)
//
// Ports
//   clk        in   1      clock, all state on rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in0_valid  in   1      channel 0 word present
//   in0_data   in   WIDTH  channel 0 word
//   in0_ready  out  1      channel 0 word accepted this cycle
//   in1_valid  in   1      channel 1 word present
//   in1_data   in   WIDTH  channel 1 word
//   in1_ready  out  1      channel 1 word accepted this cycle
//   out_valid  out  1      out_data/sel hold a word
//   out_data   out  WIDTH  registered winning word
//   sel        out  1      source index of out_data (mux select)
//   out_ready  in   1      consumer takes the word this cycle
//   gnt_cnt0   out  CNT_W  channel 0 accept count (ARB_GRANT_CNT_EN only)
//   gnt_cnt1   out  CNT_W  channel 1 accept count (ARB_GRANT_CNT_EN only)

module rr_mux2_feeder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             sel,
    input  logic             out_ready
`ifdef ARB_GRANT_CNT_EN
    ,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
`endif
);

    // Reject meaningless configurations at elaboration time.
    if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
        $error("rr_mux2_feeder: WIDTH and CNT_W must be at least 1");
    end

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               last_grant;
    logic               space;
    logic               grant_vld;
    logic               grant_idx;
    logic               accept;
    logic [WIDTH-1:0]   win_data;

    // The output register can take a new word when it is empty, or when its
    // current word leaves this cycle. out_ready while empty has no effect.
    assign space = (state == EMPTY) || out_ready;

    // Round-robin grant. A lone requester always wins. Under contention the
    // channel that did not win last time wins. last_grant resets to 1, so
    // channel 0 is favoured first after reset.
    always_comb begin
        grant_vld = in0_valid || in1_valid;
        grant_idx = 1'b0;
        if (in0_valid && in1_valid) begin
            grant_idx = ~last_grant;
        end else if (in1_valid) begin
            grant_idx = 1'b1;
        end
    end

    // Gating with rst_n keeps both readies low while reset is held. It also
    // prevents a source from seeing a handshake that the register never takes.
    assign accept    = space && grant_vld && rst_n;
    assign in0_ready = accept && !grant_idx;
    assign in1_ready = accept &&  grant_idx;
    assign win_data  = grant_idx ? in1_data : in0_data;

    // Occupancy state machine. FULL stays FULL on a stall, and also on a
    // pop with a simultaneous refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (accept) begin
                    state_nxt = FULL;
                end else if (out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    assign out_valid = (state == FULL);

    // Word, select and arbitration history only move on an accept. A pop with
    // no refill leaves out_data/sel at their last value. No accept can happen
    // during a stall, so last_grant is frozen and fairness carries across it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= '0;
            sel        <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            out_data   <= win_data;
            sel        <= grant_idx;
            last_grant <= grant_idx;
        end
    end

`ifdef ARB_GRANT_CNT_EN
    // Per-channel accept counters. They wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (in0_ready) begin
                gnt_cnt0 <= gnt_cnt0 + 1'b1;
            end
            if (in1_ready) begin
                gnt_cnt1 <= gnt_cnt1 + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rr_mux2_feeder.sv
// tb/tb_rr_mux2_feeder.sv - self-checking scoreboard bench for rr_mux2_feeder

module tb_rr_mux2_feeder;

    localparam int W  = 8;
    localparam int CW = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in0_valid = 1'b0;
    logic [W-1:0] in0_data = '0;
    logic         in0_ready;
    logic         in1_valid = 1'b0;
    logic [W-1:0] in1_data = '0;
    logic         in1_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         sel;
    logic         out_ready = 1'b0;
`ifdef ARB_GRANT_CNT_EN
    logic [CW-1:0] gnt_cnt0;
    logic [CW-1:0] gnt_cnt1;
`endif

    rr_mux2_feeder #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sel       (sel),
        .out_ready (out_ready)
`ifdef ARB_GRANT_CNT_EN
        ,
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    typedef struct packed {
        logic         s;
        logic [W-1:0] d;
    } word_t;

    word_t        sb[$];
    logic         m_full = 1'b0;
    logic         m_last = 1'b1;
    logic         m_sel  = 1'b0;
    logic [W-1:0] m_data = '0;

    // Reference model and scoreboard, evaluated mid-cycle where all inputs and
    // combinational outputs are settled for the coming rising edge.
    always @(negedge clk) begin : monitor
        logic  sp;
        logic  gv;
        logic  gi;
        logic  e0;
        logic  e1;
        word_t w;
        if (!rst_n) begin
            sb.delete();
            m_full = 1'b0;
            m_last = 1'b1;
            m_sel  = 1'b0;
            m_data = '0;
            checks++;
            if ({in0_ready, in1_ready, out_valid, sel, out_data} !== '0)
                $display("FAIL in_reset: got rdy0=%b rdy1=%b ov=%b sel=%b data=%h, expected all 0",
                         in0_ready, in1_ready, out_valid, sel, out_data);
            else
                passed++;
        end else begin
            checks++;
            if (out_valid !== m_full || out_data !== m_data || sel !== m_sel)
                $display("FAIL out_regs: got ov=%b data=%h sel=%b, expected ov=%b data=%h sel=%b",
                         out_valid, out_data, sel, m_full, m_data, m_sel);
            else
                passed++;
            sp = !m_full || out_ready;
            gv = in0_valid || in1_valid;
            gi = (in0_valid && in1_valid) ? !m_last : in1_valid;
            e0 = sp && gv && !gi;
            e1 = sp && gv && gi;
            checks++;
            if (in0_ready !== e0 || in1_ready !== e1)
                $display("FAIL readies: got rdy0=%b rdy1=%b, expected rdy0=%b rdy1=%b",
                         in0_ready, in1_ready, e0, e1);
            else
                passed++;
            if (m_full && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL pop_empty_sb: got word %h sel %b, expected no word", out_data, sel);
                end else begin
                    w = sb.pop_front();
                    if ({sel, out_data} !== w)
                        $display("FAIL pop_word: got sel=%b data=%h, expected sel=%b data=%h",
                                 sel, out_data, w.s, w.d);
                    else
                        passed++;
                end
            end
            if (sp && gv) begin
                w.s = gi;
                w.d = gi ? in1_data : in0_data;
                sb.push_back(w);
                m_full = 1'b1;
                m_last = gi;
                m_sel  = gi;
                m_data = w.d;
            end else if (out_ready) begin
                m_full = 1'b0;
            end
        end
    end

    task automatic drive(input logic v0, input logic [W-1:0] d0,
                         input logic v1, input logic [W-1:0] d1, input logic ordy);
        in0_valid = v0;
        in0_data  = d0;
        in1_valid = v1;
        in1_data  = d1;
        out_ready = ordy;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, sel, out_data} !== '0)
            $display("FAIL reset_init: got ov=%b sel=%b data=%h, expected 0 0 00", out_valid, sel, out_data);
        else
            passed++;
        rst_n = 1'b1;
        drive(1'b1, 8'h3C, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C)
            $display("FAIL reset_preload: got ov=%b data=%h, expected 1 3c", out_valid, out_data);
        else
            passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, sel, out_data} !== '0)
            $display("FAIL reset_async: got ov=%b sel=%b data=%h, expected 0 0 00", out_valid, sel, out_data);
        else
            passed++;
        drive(1'b1, 8'h44, 1'b1, 8'h55, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checks++;
        if (in0_ready !== 1'b1 || in1_ready !== 1'b0)
            $display("FAIL reset_first_grant: got rdy0=%b rdy1=%b, expected 1 0", in0_ready, in1_ready);
        else
            passed++;
        @(posedge clk);
        #1 drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        @(posedge clk);
    endtask

    task automatic test_single();
        #1 drive(1'b0, 8'h00, 1'b1, 8'hA5, 1'b1);
        #1;
        checks++;
        if (in1_ready !== 1'b1 || in0_ready !== 1'b0)
            $display("FAIL single_ready: got rdy0=%b rdy1=%b, expected 0 1", in0_ready, in1_ready);
        else
            passed++;
        @(posedge clk);
        #1 drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || sel !== 1'b1)
            $display("FAIL single_out: got ov=%b data=%h sel=%b, expected 1 a5 1", out_valid, out_data, sel);
        else
            passed++;
        @(posedge clk);
    endtask

    task automatic test_contention();
        logic [W-1:0] exp_d [4];
        exp_d[0] = 8'h11;
        exp_d[1] = 8'h22;
        exp_d[2] = 8'h11;
        exp_d[3] = 8'h22;
        #1 drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d[i] || sel !== i[0])
                $display("FAIL contention_%0d: got ov=%b data=%h sel=%b, expected 1 %h %b",
                         i, out_valid, out_data, sel, exp_d[i], i[0]);
            else
                passed++;
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        @(posedge clk);
    endtask

    task automatic test_stall();
        #1 drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in0_ready !== 1'b0 || in1_ready !== 1'b0 || out_data !== 8'h11 || sel !== 1'b0)
                $display("FAIL stall_%0d: got rdy0=%b rdy1=%b data=%h sel=%b, expected 0 0 11 0",
                         i, in0_ready, in1_ready, out_data, sel);
            else
                passed++;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in1_ready !== 1'b1 || in0_ready !== 1'b0)
            $display("FAIL stall_release: got rdy0=%b rdy1=%b, expected 0 1", in0_ready, in1_ready);
        else
            passed++;
        @(posedge clk);
        #1 drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        checks++;
        if (out_data !== 8'h22 || sel !== 1'b1)
            $display("FAIL stall_next: got data=%h sel=%b, expected 22 1", out_data, sel);
        else
            passed++;
        @(posedge clk);
    endtask

    task automatic test_drain();
        #1 drive(1'b0, 8'h00, 1'b1, 8'h5A, 1'b1);
        @(posedge clk);
        #1 drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || sel !== 1'b1 || out_data !== 8'h5A)
            $display("FAIL drain: got ov=%b sel=%b data=%h, expected 0 1 5a", out_valid, sel, out_data);
        else
            passed++;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0)
            $display("FAIL drain_idle: got ov=%b, expected 0", out_valid);
        else
            passed++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1 drive(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)), W'($urandom),
                     ($urandom_range(0, 3) != 0));
        end
        @(posedge clk);
        #1 drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        repeat (2) @(posedge clk);
    endtask

`ifdef ARB_GRANT_CNT_EN
    task automatic test_counters();
        logic [CW-1:0] e;
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        checks++;
        if (gnt_cnt0 !== '0 || gnt_cnt1 !== '0)
            $display("FAIL cnt_reset: got %0d %0d, expected 0 0", gnt_cnt0, gnt_cnt1);
        else
            passed++;
        drive(1'b1, 8'h77, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            e = CW'(i + 1);
            checks++;
            if (gnt_cnt0 !== e || gnt_cnt1 !== '0)
                $display("FAIL cnt_%0d: got cnt0=%0d cnt1=%0d, expected %0d 0", i, gnt_cnt0, gnt_cnt1, e);
            else
                passed++;
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        @(posedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_stall();
        test_drain();
        test_back_to_back();
`ifdef ARB_GRANT_CNT_EN
        test_counters();
`endif
        @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
